// File: rtl/instr_mem_ctrl.sv
// Instruction memory access controller: round-robin fetch/loader arbiter
// driving the shared fetch_en/pc/instruction port, with a turnaround after writes.
module instr_mem_ctrl #(
    parameter int AW = 6,
    parameter int DW = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          mem_fetch_en,
    output logic [AW-1:0] mem_pc,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wdata_oe,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        TURN
    } state_t;

    state_t        state_q, state_d;
    logic          last_ld_q;
    logic          arb_en;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] wdata_q;
    logic          fetch_en_q;
    logic          oe_q;
    logic          rvalid_q;
    logic          busy_q;

    // last_ld_q set means the loader won most recently, so fetch wins a tie
    assign arb_en = (state_q != WR);
    assign f_gnt  = arb_en & f_req & (~l_req | last_ld_q);
    assign l_gnt  = arb_en & l_req & (~f_req | ~last_ld_q);

    always_comb begin
        state_d = IDLE;
        unique case (1'b1)
            (state_q == WR): state_d = TURN;
            f_gnt:           state_d = RD;
            l_gnt:           state_d = WR;
            default:         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_ld_q  <= 1'b1;
            pc_q       <= '0;
            wdata_q    <= '0;
            fetch_en_q <= 1'b1;
            oe_q       <= 1'b0;
            rvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_en_q <= (state_d != WR);
            oe_q       <= (state_d == WR);
            busy_q     <= (state_d != IDLE);
            rvalid_q   <= (state_q == RD);
            if (f_gnt) begin
                pc_q      <= f_addr;
                last_ld_q <= 1'b0;
            end
            if (l_gnt) begin
                pc_q      <= l_addr;
                wdata_q   <= l_wdata;
                last_ld_q <= 1'b1;
            end
        end
    end

    assign mem_fetch_en = fetch_en_q;
    assign mem_wdata_oe = oe_q;
    assign mem_pc       = pc_q;
    assign mem_wdata    = wdata_q;
    assign f_rvalid     = rvalid_q;
    assign f_rdata      = mem_rdata;
    assign busy         = busy_q;

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Access controller for the 64 x 30-bit instruction memory. Arbitrates between the fetch unit (reads) and the program loader (writes) and sequences the memory's single shared `fetch_en`/`pc`/`instruction` port. Guarantees the memory's write strobe (`fetch_en` low) is asserted only for a granted write. Inserts a bus-turnaround cycle after every write. Sits between the core's fetch stage, the loader, and `instr_mem`.

## Interface
- `AW`, 6, address width (memory depth 2^AW)
- `DW`, 30, instruction width
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `f_req`  in  1  fetch requests a read
- `f_addr`  in  AW  fetch read address
- `f_gnt`  out  1  combinational; read accepted this cycle when `f_req & f_gnt`
- `f_rvalid`  out  1  registered; read data valid this cycle
- `f_rdata`  out  DW  equals `mem_rdata`; meaningful only when `f_rvalid`
- `l_req`  in  1  loader requests a write
- `l_addr`  in  AW  loader write address
- `l_wdata`  in  DW  loader write data
- `l_gnt`  out  1  combinational; write accepted this cycle when `l_req & l_gnt`
- `mem_fetch_en`  out  1  to memory; 0 only in WR state
- `mem_pc`  out  AW  to memory address
- `mem_wdata`  out  DW  write data to the shared instruction bus
- `mem_wdata_oe`  out  1  drive enable for `mem_wdata` onto the bus; 1 only in WR
- `mem_rdata`  in  DW  instruction bus as read back from memory
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, RD, WR, TURN.
- Arbitration is evaluated in IDLE, RD and TURN only. In WR, `f_gnt = l_gnt = 0`.
- Arbitration rules:
  - One requester pending: grant it.
  - Both pending: grant the one not granted last (round-robin pointer `last`, updated on every grant).
  - Reset sets `last` = loader, so fetch wins the first tie.
- Read grant: latch `f_addr` into `mem_pc`; next state RD.
- Write grant: latch `l_addr` and `l_wdata`; next state WR.
- No grant: next state IDLE. `mem_pc` holds its last value.
- WR always goes to TURN.
- RD state: `mem_fetch_en=1`, `mem_wdata_oe=0`. The memory captures `mem[mem_pc]` at the end of RD.
- WR state: `mem_fetch_en=0`, `mem_wdata_oe=1`, `mem_wdata` = latched data. The memory writes at the end of WR.
- TURN state: `mem_fetch_en=1`, `mem_wdata_oe=0`; no memory access.
- IDLE state: `mem_fetch_en=1`, `mem_wdata_oe=0`.
- Invariant: exactly one cycle of `mem_fetch_en=0` per accepted write, and none otherwise.
- `f_rvalid` is a registered copy of (state == RD). Reads return in order.
- Requesters hold `req`/`addr`/`wdata` stable until accepted. A requester may drop `req` only after acceptance.

## Timing
- Reset values:
  - State IDLE, `last` = loader.
  - `mem_fetch_en=1`, `mem_wdata_oe=0`, `mem_pc=0`, `mem_wdata=0`.
  - `f_rvalid=0`, `busy=0`.
  - `f_gnt`/`l_gnt` follow the IDLE arbitration.
- Read: accepted in cycle N → RD in N+1 → `f_rvalid=1` in N+2 with data. Latency is 2 cycles.
- Back-to-back reads: one accept per cycle; `f_rvalid` is continuous one-per-cycle, two cycles behind.
- Write: accepted in N → WR in N+1 (memory written at end of N+1) → TURN in N+2. The next grant is possible in N+2 and its access occurs in N+3.
- Read immediately following a write to the same address returns the new data.
- Reset mid-operation:
  - `rst_n` low at the edge ending WR: the memory write still completes (the memory saw `fetch_en=0` at that edge). The controller enters IDLE.
  - Reset during RD: the pending `f_rvalid` is suppressed (0 after reset).
- Accepts in the same cycle as reset are discarded.

## Test plan
- Reset: hold `rst_n=0` 3 cycles with both reqs high → `mem_fetch_en=1`, `mem_wdata_oe=0`, `f_rvalid=0`, `busy=0`, state IDLE after release.
- Write then read: write addr 5 = 0x2ABCDEF1, then read addr 5 → `l_gnt` at N; WR at N+1 with `mem_fetch_en=0` for exactly 1 cycle; `f_gnt` at N+2; `f_rvalid=1` at N+4 with `f_rdata=0x2ABCDEF1`.
- Streaming reads: `f_req` held for addresses 0..3 of the initialised memory → 4 consecutive `f_gnt`, then 4 consecutive `f_rvalid` each with data 0x0000001; `mem_fetch_en` stays 1 throughout.
- Contention: both reqs held continuously from reset → grants alternate fetch, loader, fetch, loader. Each loader grant is followed by WR and TURN, with no grant in the WR cycle.
- Strobe invariant: random reqs for 2000 cycles → count of `mem_fetch_en=0` cycles equals count of write accepts. `mem_wdata_oe` equals `~mem_fetch_en` every cycle.
- Reset during WR: assert `rst_n=0` in the WR cycle of a write to addr 9 = 0x155 → after reset, a read of addr 9 returns 0x155; no `f_rvalid` is produced during the reset cycles.
